// File: rtl/oh_abs_pipe_stage.sv
// One pipeline register stage: valid bit plus per-lane data and overflow flags.
// Loads everything on i_load; reset clears valid, data and flags.
module oh_abs_pipe_stage #(
  parameter int N = 32,
  parameter int L = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_load,
  input  logic           i_valid,
  input  logic [L*N-1:0] i_data,
  input  logic [L-1:0]   i_ovf,
  output logic           o_valid,
  output logic [L*N-1:0] o_data,
  output logic [L-1:0]   o_ovf
);

  logic           r_valid;
  logic [L*N-1:0] r_data;
  logic [L-1:0]   r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
      r_ovf   <= i_ovf;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/oh_abs_pipe.sv
// Multi-lane pipelined absolute value with optional saturation of the max-negative input
// and a saturating count of overflowed lanes seen at the output handshake.
module oh_abs_pipe #(
  parameter int N  = 32,
  parameter int L  = 1,
  parameter int S  = 2,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L*N-1:0] in_data,
  input  logic           sat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L*N-1:0] out_data,
  output logic [L-1:0]   out_ovf,
  input  logic           ovf_clr,
  output logic [CW-1:0]  ovf_count
);

  localparam logic [N-1:0] MaxNeg = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
  localparam int           SW     = CW + L;
  localparam logic [SW-1:0] CntMax = SW'({CW{1'b1}});

  logic [L*N-1:0] w_abs;
  logic [L-1:0]   w_ovf;

  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [N-1:0] w_in;
    logic [N-1:0] w_neg;
    assign w_in     = in_data[k*N +: N];
    assign w_neg    = '0 - w_in;
    assign w_ovf[k] = (w_in == MaxNeg);
    assign w_abs[k*N +: N] = w_ovf[k] ? (sat ? MaxPos : MaxNeg)
                                      : (w_in[N-1] ? w_neg : w_in);
  end

  logic [S-1:0]   w_valid;
  logic [S-1:0]   w_load;
  logic [L*N-1:0] w_data [S];
  logic [L-1:0]   w_sovf [S];

  // A stage loads when empty or when its successor is taking its contents this cycle.
  always_comb begin
    logic w_take;
    w_take = out_ready;
    for (int i = S - 1; i >= 0; i--) begin
      w_take    = ~w_valid[i] | w_take;
      w_load[i] = w_take;
    end
  end

  for (genvar i = 0; i < S; i++) begin : g_stage
    logic           w_src_valid;
    logic [L*N-1:0] w_src_data;
    logic [L-1:0]   w_src_ovf;

    if (i == 0) begin : g_first
      assign w_src_valid = in_valid;
      assign w_src_data  = w_abs;
      assign w_src_ovf   = w_ovf;
    end else begin : g_rest
      assign w_src_valid = w_valid[i-1];
      assign w_src_data  = w_data[i-1];
      assign w_src_ovf   = w_sovf[i-1];
    end

    oh_abs_pipe_stage #(
      .N (N),
      .L (L)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[i]),
      .i_valid (w_src_valid),
      .i_data  (w_src_data),
      .i_ovf   (w_src_ovf),
      .o_valid (w_valid[i]),
      .o_data  (w_data[i]),
      .o_ovf   (w_sovf[i])
    );
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_valid[S-1];
  assign out_data  = w_data[S-1];
  assign out_ovf   = w_sovf[S-1];

  logic [CW-1:0] r_count;
  logic [SW-1:0] w_inc;
  logic [SW-1:0] w_sum;

  always_comb begin
    w_inc = '0;
    for (int k = 0; k < L; k++) begin
      w_inc = w_inc + SW'(out_ovf[k]);
    end
  end

  assign w_sum = SW'(r_count) + w_inc;

  // Clear wins over a coincident overflow beat; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (ovf_clr) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= (w_sum > CntMax) ? '1 : w_sum[CW-1:0];
    end
  end

  assign ovf_count = r_count;

endmodule

// File: tb/tb_oh_abs_pipe.sv
// Self-checking bench for oh_abs_pipe (N=8, L=2, S=2, CW=4): directed cases plus
// randomized traffic scored against a queue-based abs model.
module tb_oh_abs_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_ovf;
  logic        ovf_clr = 1'b0;
  logic [3:0]  ovf_count;

  oh_abs_pipe #(
    .N  (8),
    .L  (2),
    .S  (2),
    .CW (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_out = 0;
  logic [17:0] exp_q[$];
  int mcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Returns {ovf[1:0], data[15:0]} from signed arithmetic on each byte lane.
  function automatic logic [17:0] model_beat(input logic [15:0] d, input logic s);
    logic [15:0] r;
    logic [1:0]  o;
    int v;
    for (int k = 0; k < 2; k++) begin
      v = int'($signed(d[k*8 +: 8]));
      o[k] = (v == -128);
      if (v == -128) r[k*8 +: 8] = s ? 8'h7F : 8'h80;
      else r[k*8 +: 8] = 8'(v < 0 ? -v : v);
    end
    return {o, r};
  endfunction

  function automatic logic [7:0] pick_lane();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return 8'($urandom());
    endcase
  endfunction

  // Per-cycle compare process, sampling on the falling edge.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [1:0]  prev_ovf;
    logic [17:0] e;
    int          inc;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_ovf   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mcount = 0;
        prev_stall = 1'b0;
      end else begin
        check("ovf_count", 32'(ovf_count), 32'(mcount));
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(prev_data));
          check("stall_ovf", 32'(out_ovf), 32'(prev_ovf));
        end
        inc = 0;
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("spurious_beat", 32'(out_data), 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[15:0]));
            check("out_ovf", 32'(out_ovf), 32'(e[17:16]));
            inc = int'(e[16]) + int'(e[17]);
          end
        end
        if (ovf_clr) mcount = 0;
        else if (out_valid && out_ready) mcount = (mcount + inc > 15) ? 15 : mcount + inc;
        if (in_valid && in_ready) exp_q.push_back(model_beat(in_data, sat));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_ovf   = out_ovf;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_one(input logic [15:0] d, input logic s, input logic [15:0] exp_d,
                          input logic [1:0] exp_o, input logic [3:0] exp_cnt);
    tick();
    in_valid = 1'b1;
    in_data  = d;
    sat      = s;
    out_ready = 1'b1;
    @(negedge clk);
    check("one_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("one_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("one_lat2_valid", 32'(out_valid), 32'd1);
    check("one_data", 32'(out_data), 32'(exp_d));
    check("one_ovf", 32'(out_ovf), 32'(exp_o));
    tick();
    @(negedge clk);
    check("one_count", 32'(ovf_count), 32'(exp_cnt));
    check("one_after_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int base;
    int stale;
    logic seen_low;
    logic found;

    check("model_ovf_wrap", 32'(model_beat(16'h80FB, 1'b0)), 32'h2_8005);
    check("model_ovf_sat", 32'(model_beat(16'h80FB, 1'b1)), 32'h2_7F05);
    check("model_edges", 32'(model_beat(16'h7FFF, 1'b1)), 32'h0_7F01);

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(ovf_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);

    send_one(16'h80FB, 1'b0, 16'h8005, 2'b10, 4'd1);
    send_one(16'h80FB, 1'b1, 16'h7F05, 2'b10, 4'd2);

    // Stream of 10 beats with a three-cycle output stall.
    sent = 0;
    seen_low = 1'b0;
    base = n_out;
    for (int cyc = 0; cyc < 40 && sent < 10; cyc++) begin
      tick();
      in_valid  = 1'b1;
      in_data   = {8'(cyc * 37), 8'(8'h80 - 8'(cyc))};
      sat       = 1'(cyc);
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (in_ready) sent++;
      else seen_low = 1'b1;
    end
    tick();
    drain();
    check("stream_sent", 32'(sent), 32'd10);
    check("stream_in_ready_low", 32'(seen_low), 32'd1);
    check("stream_out_count", 32'(n_out - base), 32'd10);

    // Saturating count, then clear coincident with an overflow beat.
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h8080;
      sat      = 1'($urandom());
      tick();
    end
    drain();
    @(negedge clk);
    check("sat_count", 32'(ovf_count), 32'd15);
    tick();
    in_valid = 1'b1;
    in_data  = 16'h8080;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("clr_beat_found", 32'(found), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    check("clr_beat_fire", 32'(out_valid && out_ready), 32'd1);
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_priority", 32'(ovf_count), 32'd0);

    // Reset with two beats in flight.
    send_one(16'h0080, 1'b0, 16'h0080, 2'b01, 4'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'h8001;
    tick();
    in_data  = 16'h0580;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("inflight_valid", 32'(out_valid), 32'd1);
    tick();
    reset    = 1'b1;
    in_valid = 1'b1;
    ovf_clr  = 1'b0;
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_count", 32'(ovf_count), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst2_no_stale", 32'(stale), 32'd0);

    // Randomized traffic against the model.
    base = n_out;
    for (int i = 0; i < 600; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {pick_lane(), pick_lane()};
      sat       = 1'($urandom());
      ovf_clr   = ($urandom_range(0, 31) == 0);
    end
    tick();
    drain();
    check("rand_progress", 32'(n_out - base > 100), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
